// File: rtl/sparse_tok_pkg.sv
// Sparse stream token encoding shared by scanner, reader and joiner units.
`timescale 1ns/1ps
package sparse_tok_pkg;

   localparam int DATA_WIDTH = 17;

   localparam logic [16:0] TOK_STOP0 = 17'h10000;
   localparam logic [16:0] TOK_DONE  = 17'h10100;
   localparam logic [16:0] TOK_EMPTY = 17'h10200;

   typedef enum logic [1:0] {
      COORD,
      STOP,
      DONE
   } tok_kind_e;

   function automatic tok_kind_e tok_kind(input logic [16:0] t);
      if (!t[16])
         return COORD;
      else if (t == TOK_DONE)
         return DONE;
      else
         return STOP;
   endfunction

   function automatic logic [16:0] stop_tok(input logic [7:0] lvl);
      return {1'b1, 8'h00, lvl};
   endfunction

endpackage

// File: rtl/joiner_min_tree.sv
// Minimum over the active coordinate heads plus a mask of heads equal to it.
`timescale 1ns/1ps
module joiner_min_tree #(
   parameter int N = 2,
   parameter int W = 16
) (
   input  logic [N*W-1:0] val,
   input  logic [N-1:0]   act,
   output logic [W-1:0]   min_o,
   output logic [N-1:0]   eq_o
);

   logic [W-1:0] m;

   // Inactive heads behave as +inf and never match.
   always_comb begin
      m = '1;
      for (int i = 0; i < N; i++) begin
         if (act[i] && (val[i*W +: W] < m))
            m = val[i*W +: W];
      end
      eq_o = '0;
      for (int i = 0; i < N; i++) begin
         eq_o[i] = act[i] && (val[i*W +: W] == m);
      end
      min_o = m;
   end

endmodule

// File: rtl/multi_joiner_unit.sv
// N-input intersect/union joiner of sorted coordinate streams with
// aligned position streams and a per-channel one-entry output register.
`timescale 1ns/1ps
module multi_joiner_unit #(
   parameter int NUM_IN     = 2,
   parameter int DATA_WIDTH = sparse_tok_pkg::DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clk_en,
   input  logic                         flush,
   input  logic                         tile_en,
   input  logic                         joiner_op,
   input  logic [NUM_IN*DATA_WIDTH-1:0] coord_in,
   input  logic [NUM_IN-1:0]            coord_in_valid,
   output logic [NUM_IN-1:0]            coord_in_ready,
   input  logic [NUM_IN*DATA_WIDTH-1:0] pos_in,
   input  logic [NUM_IN-1:0]            pos_in_valid,
   output logic [NUM_IN-1:0]            pos_in_ready,
   output logic [DATA_WIDTH-1:0]        coord_out,
   output logic                         coord_out_valid,
   input  logic                         coord_out_ready,
   output logic [NUM_IN*DATA_WIDTH-1:0] pos_out,
   output logic [NUM_IN-1:0]            pos_out_valid,
   input  logic [NUM_IN-1:0]            pos_out_ready,
   output logic                         done,
   output logic                         error
);
   import sparse_tok_pkg::*;

   localparam int DW = DATA_WIDTH;
   localparam int PW = DATA_WIDTH - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   state_e                 state_q, state_d;
   logic                   op_q, op_d;
   logic                   err_q, err_d;
   logic [NUM_IN:0]        vld_q, vld_d;
   logic [DW-1:0]          cout_q, cout_d;
   logic [NUM_IN*DW-1:0]   pout_q, pout_d;

   logic [NUM_IN-1:0]      is_coord, is_done, eq, pop;
   logic [NUM_IN*PW-1:0]   pay;
   logic [PW-1:0]          min_c;
   logic [7:0]             max_lvl;
   logic                   lvl_eq;
   logic [NUM_IN:0]        clr, rem;
   logic                   go, op, emit, fin, mism;
   logic [DW-1:0]          ctok;
   logic [NUM_IN*DW-1:0]   ptok;

   always_comb begin
      pay     = '0;
      max_lvl = '0;
      lvl_eq  = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
         is_coord[i] = tok_kind(coord_in[i*DW +: DW]) == COORD;
         is_done[i]  = tok_kind(coord_in[i*DW +: DW]) == DONE;
         pay[i*PW +: PW] = coord_in[i*DW +: PW];
         if (coord_in[i*DW +: 8] > max_lvl)
            max_lvl = coord_in[i*DW +: 8];
         if (coord_in[i*DW +: 8] != coord_in[7:0])
            lvl_eq = 1'b0;
      end
   end

   joiner_min_tree #(
      .N (NUM_IN),
      .W (PW)
   ) u_min (
      .val   (pay),
      .act   (is_coord),
      .min_o (min_c),
      .eq_o  (eq)
   );

   always_comb begin
      ctok = cout_q;
      ptok = pout_q;
      pop  = '0;
      emit = 1'b0;
      fin  = 1'b0;
      mism = 1'b0;
      op   = (state_q == ST_IDLE) ? joiner_op : op_q;
      if (|is_coord) begin
         if (op) begin
            emit = 1'b1;
            pop  = eq;
            ctok = {1'b0, min_c};
            for (int i = 0; i < NUM_IN; i++)
               ptok[i*DW +: DW] = eq[i] ? pos_in[i*DW +: DW] : TOK_EMPTY;
         end else if (&eq) begin
            emit = 1'b1;
            pop  = '1;
            ctok = {1'b0, min_c};
            ptok = pos_in;
         end else if (&is_coord) begin
            pop = eq;
         end else begin
            // Intersect cannot match past a stop; drain the coords.
            pop = is_coord;
         end
      end else if (&is_done) begin
         emit = 1'b1;
         pop  = '1;
         fin  = 1'b1;
         ctok = TOK_DONE;
         ptok = {NUM_IN{TOK_DONE}};
      end else begin
         emit = 1'b1;
         pop  = '1;
         mism = ~lvl_eq;
         ctok = stop_tok(max_lvl);
         ptok = {NUM_IN{stop_tok(max_lvl)}};
      end
   end

   always_comb begin
      clr = tile_en ? {coord_out_ready, pos_out_ready} : '0;
      rem = vld_q & ~clr;
      go  = ~rst & clk_en & tile_en & ~flush
          & (&(coord_in_valid & pos_in_valid))
          & (rem == '0) & (state_q != ST_DONE);
      state_d = state_q;
      op_d    = op_q;
      err_d   = err_q | (go & mism);
      vld_d   = rem;
      cout_d  = cout_q;
      pout_d  = pout_q;
      if (go) begin
         if (emit) begin
            vld_d  = '1;
            cout_d = ctok;
            pout_d = ptok;
         end
         if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            op_d    = joiner_op;
         end
         if (fin)
            state_d = ST_DONE;
      end
      if (flush) begin
         state_d = ST_IDLE;
         op_d    = 1'b0;
         vld_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= 1'b0;
         err_q   <= 1'b0;
         vld_q   <= '0;
         cout_q  <= '0;
         pout_q  <= '0;
      end else if (clk_en) begin
         state_q <= state_d;
         op_q    <= op_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
         cout_q  <= cout_d;
         pout_q  <= pout_d;
      end
   end

   assign coord_in_ready  = go ? pop : '0;
   assign pos_in_ready    = go ? pop : '0;
   assign coord_out       = cout_q;
   assign pos_out         = pout_q;
   assign coord_out_valid = tile_en & vld_q[NUM_IN];
   assign pos_out_valid   = {NUM_IN{tile_en}} & vld_q[NUM_IN-1:0];
   assign done            = state_q == ST_DONE;
   assign error           = err_q;

endmodule
